// File: rtl/seg_pkg.sv
// seg_pkg: shared segment constants, FSM encoding and frame type for the display scanner
package seg_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp_en;
        logic [3:0]  blank;
    } frame_t;
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: hex nibble to active-low {g,f,e,d,c,b,a} cathode pattern
module hex_to_seg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    localparam logic [6:0] LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    assign seg = LUT[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit common-anode 7-seg scanner stepped by edges of an async refresh wave,
// with blanking between digits, per-frame input latching and a stalled-refresh flag
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int BLANK_CYCLES = 16,
    parameter int STALL_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        refresh_in,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic [3:0]  blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        stale
);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam logic [BW-1:0] B_LOAD = BW'(BLANK_CYCLES - 1);
    localparam logic [SW-1:0] S_MAX = SW'(STALL_CYCLES - 1);

    state_t        state, state_d;
    frame_t        frame;
    logic [1:0]    sync;
    logic          prev, step, live, accept, go_show, stall_hit;
    logic [BW-1:0] bcnt;
    logic [SW-1:0] scnt;
    logic [1:0]    idx_n;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;

    hex_to_seg u_hex (.nib(frame.value[{digit_idx, 2'b00} +: 4]), .seg(seg_d));

    // live is low after reset or stale; the next step then restarts via BLANK without advancing
    always_comb begin
        accept    = step && (state == ST_SHOW || !live);
        stall_hit = !step && scnt == S_MAX;
        go_show   = state == ST_BLANK && live && bcnt == '0;
        idx_n     = live ? digit_idx + 2'd1 : digit_idx;
        an_d      = frame.blank[digit_idx] ? 4'hF : ~(4'b0001 << digit_idx);
        state_d   = (stall_hit || accept) ? ST_BLANK : go_show ? ST_SHOW : state;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= ST_BLANK;
        else state <= state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync      <= '0;
            prev      <= 1'b0;
            step      <= 1'b0;
            live      <= 1'b0;
            stale     <= 1'b0;
            bcnt      <= '0;
            scnt      <= '0;
            digit_idx <= '0;
            frame     <= '0;
            an        <= 4'hF;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            sync  <= {sync[0], refresh_in};
            prev  <= sync[1];
            step  <= sync[1] ^ prev;
            scnt  <= step ? '0 : (scnt == S_MAX) ? scnt : scnt + 1'b1;
            stale <= step ? 1'b0 : (scnt == S_MAX) ? 1'b1 : stale;
            live  <= step ? 1'b1 : stall_hit ? 1'b0 : live;
            if (accept) begin
                digit_idx <= idx_n;
                bcnt      <= B_LOAD;
                if (idx_n == 2'd0) frame <= {value, dp_en, blank};
            end else if (state == ST_BLANK && bcnt != '0) begin
                bcnt <= bcnt - 1'b1;
            end
            if (stall_hit || accept) begin
                an  <= 4'hF;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else if (go_show) begin
                an  <= an_d;
                seg <= seg_d;
                dp  <= ~frame.dp_en[digit_idx];
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench; stimulus queues expected digits, a monitor checks each shown digit
module tb_seg_scan_driver;
    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         gap;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0, refresh_in = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_en = '0, blank = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, stale;
    logic [1:0]  digit_idx;

    exp_t       q[$];
    int         vec = 0, bad = 0, frun = 0;
    logic       sb_en = 1'b0;
    logic [3:0] prev_an = 4'hF;

    seg_scan_driver dut (
        .clk(clk), .rst(rst), .refresh_in(refresh_in), .value(value), .dp_en(dp_en),
        .blank(blank), .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx), .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vec++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sb_en && an !== 4'hF && prev_an === 4'hF) begin
            if (q.size() == 0) chk("unexpected_digit", {28'd0, an}, 32'hF);
            else begin
                e = q.pop_front();
                chk("digit_an_seg_dp", {an, seg, dp}, {e.an, e.seg, e.dp});
                if (e.gap != 0) chk("blank_gap", frun, e.gap);
            end
        end
        frun = (an === 4'hF) ? frun + 1 : 0;
        prev_an = an;
    end

    task automatic tog(input logic [3:0] a, input logic [6:0] s, input logic d, input int gap, input int n);
        if (a != 4'hF) q.push_back('{a, s, d, gap});
        refresh_in = ~refresh_in;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n, last, mind, adv;
        logic flag;
        logic [1:0] pidx;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            repeat (3) begin
                refresh_in = ~refresh_in;
                @(negedge clk);
            end
            chk("reset_outputs", {an, seg, dp, stale, digit_idx}, {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0});
        end
        refresh_in = 1'b0;
        value = 16'h1234;
        @(negedge clk);
        #2 rst = 1'b1;
        flag = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1 if (an !== 4'hF || stale !== 1'b0) flag = 1'b1;
        end
        chk("dark_after_release", flag, 0);
        sb_en = 1'b1;
        @(negedge clk);
        tog(4'hE, 7'h19, 1'b1, 0, 200);
        tog(4'hD, 7'h30, 1'b1, 16, 200);
        tog(4'hB, 7'h24, 1'b1, 16, 200);
        tog(4'h7, 7'h79, 1'b1, 16, 200);
        tog(4'hE, 7'h19, 1'b1, 16, 200);
        tog(4'hD, 7'h30, 1'b1, 16, 200);
        tog(4'hB, 7'h24, 1'b1, 16, 200);
        chk("idx_at_value_change", digit_idx, 2);
        value = 16'hABCD;
        tog(4'h7, 7'h79, 1'b1, 16, 200);
        blank = 4'b0100;
        dp_en = 4'b0001;
        tog(4'hE, 7'h21, 1'b0, 16, 200);
        tog(4'hD, 7'h46, 1'b1, 16, 200);
        tog(4'hF, 7'h7F, 1'b1, 0, 60);
        chk("slot2_dark", an, 4'hF);
        chk("slot2_idx", digit_idx, 2);
        repeat (140) @(negedge clk);
        tog(4'h7, 7'h08, 1'b1, 0, 200);
        n = 200;
        while (stale !== 1'b1 && n < 70000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("stale_latency", (n >= 65536 && n <= 65544) ? 65540 : n, 65540);
        chk("stale_dark", {stale, an}, {1'b1, 4'hF});
        @(negedge clk);
        q.push_back('{4'h7, 7'h08, 1'b1, 0});
        refresh_in = ~refresh_in;
        n = 0;
        while (stale !== 1'b0 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        chk("stale_clear_latency", (n <= 4) ? 4 : n, 4);
        flag = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1 if (an !== 4'hF) flag = 1'b1;
        end
        chk("resume_via_blank", flag, 0);
        repeat (10) @(negedge clk);
        chk("resume_idx", digit_idx, 3);
        sb_en = 1'b0;
        flag = 1'b0;
        last = 0;
        mind = 1000;
        adv = 0;
        pidx = digit_idx;
        for (int c = 1; c <= 400; c++) begin
            if (c % 4 == 0) refresh_in = ~refresh_in;
            @(negedge clk);
            if ($isunknown({an, seg, dp, digit_idx, stale})) flag = 1'b1;
            if (digit_idx !== pidx) begin
                adv++;
                if (last != 0 && c - last < mind) mind = c - last;
                last = c;
            end
            pidx = digit_idx;
        end
        chk("fast_no_x", flag, 0);
        chk("fast_min_idx_period", (mind >= 17) ? 17 : mind, 17);
        chk("fast_advances", (adv >= 10) ? 10 : adv, 10);
        n = 0;
        while (an === 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("shown_before_reset", an !== 4'hF, 1);
        #2 rst = 1'b0;
        #1 chk("mid_reset", {an, seg, dp, stale, digit_idx}, {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0});
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
